// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between
// instruction fetch (port 0, read-only) and load/store (port 1).
module mem_port_arbiter #(
    parameter int unsigned DW      = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [DW-1:0] addr0,
    input  logic          req1,
    input  logic [DW-1:0] addr1,
    input  logic          we1,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_sel,
    output logic [DW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_en,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          busy
);

    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          last_q, last_nxt;
    logic [CW-1:0] cnt_q, cnt_nxt;
    logic          win1;

    logic          mem_sel_nxt;
    logic [DW-1:0] mem_addr_nxt;
    logic          mem_we_nxt;
    logic [DW-1:0] mem_wdata_nxt;
    logic          mem_en_nxt;
    logic          gnt0_nxt;
    logic          gnt1_nxt;
    logic          done0_nxt;
    logic          done1_nxt;
    logic [DW-1:0] rdata_nxt;
    logic          busy_nxt;

    // State, pointer, counter and output registers; reset aborts any access
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            mem_sel   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            mem_en    <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_q    <= last_nxt;
            cnt_q     <= cnt_nxt;
            mem_sel   <= mem_sel_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_we    <= mem_we_nxt;
            mem_wdata <= mem_wdata_nxt;
            mem_en    <= mem_en_nxt;
            gnt0      <= gnt0_nxt;
            gnt1      <= gnt1_nxt;
            done0     <= done0_nxt;
            done1     <= done1_nxt;
            rdata     <= rdata_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state and next-output logic: arbitrate, hold the access, pulse done
    always_comb begin
        state_nxt     = state;
        last_nxt      = last_q;
        cnt_nxt       = cnt_q;
        win1          = 1'b0;
        mem_sel_nxt   = mem_sel;
        mem_addr_nxt  = mem_addr;
        mem_we_nxt    = mem_we;
        mem_wdata_nxt = mem_wdata;
        mem_en_nxt    = mem_en;
        gnt0_nxt      = gnt0;
        gnt1_nxt      = gnt1;
        done0_nxt     = 1'b0;
        done1_nxt     = 1'b0;
        rdata_nxt     = rdata;
        busy_nxt      = busy;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // Port 1 wins alone, or on a tie when port 0 was served last
                    win1          = req1 & (~req0 | ~last_q);
                    mem_sel_nxt   = win1;
                    mem_addr_nxt  = win1 ? addr1 : addr0;
                    mem_we_nxt    = win1 & we1;
                    mem_wdata_nxt = win1 ? wdata1 : '0;
                    mem_en_nxt    = 1'b1;
                    gnt0_nxt      = ~win1;
                    gnt1_nxt      = win1;
                    busy_nxt      = 1'b1;
                    cnt_nxt       = CW'(MEM_LAT - 1);
                    state_nxt     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!mem_we) begin
                        rdata_nxt = mem_rdata;
                    end
                    mem_en_nxt = 1'b0;
                    mem_we_nxt = 1'b0;
                    gnt0_nxt   = 1'b0;
                    gnt1_nxt   = 1'b0;
                    done0_nxt  = ~mem_sel;
                    done1_nxt  = mem_sel;
                    last_nxt   = mem_sel;
                    state_nxt  = DONE;
                end else begin
                    cnt_nxt = cnt_q - CW'(1);
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 16-bit memory port of the multicycle RISC core between two requesters: instruction fetch (port 0) and load/store data access (port 1).
- Runs round-robin arbitration and latches the winner's address, write enable and write data.
- Drives the select line of the 16-bit 2:1 address/data muxes in front of memory and sequences a fixed-latency access.
- Returns read data to the winner with a one-cycle done pulse.

Parameters:
- DW, 16, data/address width.
- MEM_LAT, 2, memory access cycles (1..15). MEM_LAT < 1 is illegal.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset. One clock; reset is synchronous and active-low.
- req0  input  1  fetch request.
- addr0  input  DW  fetch address.
- req1  input  1  data request.
- addr1  input  DW  data address.
- we1  input  1  data write enable. Port 0 is read-only.
- wdata1  input  DW  data write value.
- mem_rdata  input  DW  memory read data, valid in the last access cycle.
- mem_sel  output  1  mux select: 0 = port 0, 1 = port 1.
- mem_addr  output  DW  latched address to memory.
- mem_we  output  1  memory write strobe.
- mem_wdata  output  DW  latched write data.
- mem_en  output  1  memory access enable.
- gnt0, gnt1  output  1 each  grant, high for the whole ACCESS phase.
- done0, done1  output  1 each  one-cycle completion pulse.
- rdata  output  DW  registered read data, shared by both ports.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, DONE. All outputs are registered.
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE and the last-served pointer goes to 1, so port 0 wins the first tie.
  - Outputs cleared: mem_sel, mem_addr, mem_we, mem_wdata, mem_en, gnt0, gnt1, done0, done1, rdata, busy, cycle counter.
  - Reset mid-ACCESS aborts the access immediately: no done pulse, rdata not updated, mem_we drops the next cycle.
- IDLE:
  - Arbitrate on sampled req0/req1.
  - Only one request high: that port wins.
  - Both high: the port not served last wins.
  - No request: stay in IDLE.
  - On a win: latch addr/we/wdata of the winner, set mem_sel, gntN, mem_en and busy, load counter = MEM_LAT-1, go to ACCESS.
  - we for port 0 is forced to 0.
- ACCESS:
  - mem_addr, mem_we, mem_wdata, mem_sel and gnt are held stable for exactly MEM_LAT cycles.
  - The counter decrements each cycle.
  - Counter = 0: capture mem_rdata into rdata (reads only; rdata is unchanged on writes), clear gnt, mem_en and mem_we, pulse doneN, update the last-served pointer, go to DONE.
- DONE:
  - doneN is high for this one cycle.
  - Next cycle returns to IDLE; doneN and busy drop.
  - mem_sel holds its last value; it does not return to 0.
- Latency: a request sampled at edge E gives gnt from E to E+MEM_LAT, and done high for the cycle after E+MEM_LAT. The minimum repeat interval is MEM_LAT+2 cycles.
- Requester protocol:
  - Hold req, addr, we and wdata stable until done.
  - Deassert req at the edge ending the done cycle. Any req still high in the following IDLE cycle is a new request.
  - Inputs changing during ACCESS are ignored because the values are latched.
  - req dropped during ACCESS does not cancel the access; done still pulses.
- Simultaneous events:
  - The loser keeps its request pending and wins at the next IDLE.
  - A request arriving during ACCESS/DONE waits for IDLE.
  - With both ports continuously requesting, service strictly alternates, so neither port starves.
- Arithmetic: the counter is 4 bits with no wrap, because it is reloaded on every grant.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release with no req. All outputs stay 0 and busy=0 for 5 cycles.
- Single fetch read, MEM_LAT=2: req0=1, addr0=16'h0010, memory returns 16'hBEEF in the last access cycle.
  - mem_sel=0, mem_addr=0010, gnt0 high for 2 cycles.
  - done0 pulses on cycle 3 with rdata=BEEF. mem_we stays 0.
- Data write: req1=1, we1=1, addr1=16'h0200, wdata1=16'h1234.
  - mem_sel=1, mem_we=1, mem_wdata=1234 for exactly 2 cycles.
  - done1 pulses; rdata unchanged.
- Contention after reset: req0 and req1 asserted together and held.
  - Port 0 is served first, then port 1, then port 0 again.
  - done pulses alternate and are spaced MEM_LAT+2=4 cycles apart.
- Input change mid-access: change addr1 to 16'hFFFF during ACCESS. mem_addr keeps the latched value for the whole access.
- Reset mid-access: rst_n=0 in ACCESS cycle 1.
  - Next cycle: IDLE with gnt=0 and mem_we=0.
  - No done pulse; rdata=0.
